// File: rtl/host_sequencer.sv
// Host-side run sequencer: preloads data memory from a byte stream, pulses
// the core through reset and start, times the run, then streams a result
// region of data memory back out. Owns the memory port while the core is idle.
module host_sequencer #(
  parameter int          AW        = 8,
  parameter int unsigned LOAD_BASE = 0,
  parameter int          LOAD_LEN  = 64,
  parameter int unsigned READ_BASE = 64,
  parameter int          READ_LEN  = 32,
  parameter logic [15:0] MAX_CYC   = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_dat,
  input  logic [7:0]    mem_rd_dat,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          res_valid,
  output logic [7:0]    res_data,
  input  logic          res_ready,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [15:0]   cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CRST, S_REQ, S_RUN, S_DRAIN, S_DONE
  } state_t;

  localparam logic [15:0]   LOAD_LAST = 16'(LOAD_LEN - 1);
  localparam logic [15:0]   READ_LAST = 16'(READ_LEN - 1);
  localparam logic [15:0]   RUN_LIMIT = MAX_CYC - 16'd1;
  localparam logic [AW-1:0] LBASE     = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RBASE     = AW'(READ_BASE);
  localparam state_t        FIRST     = (LOAD_LEN == 0) ? S_CRST : S_LOAD;
  localparam state_t        AFTER_RUN = (READ_LEN == 0) ? S_DONE : S_DRAIN;

  state_t      state, state_nx;
  logic [15:0] idx, rdx;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Byte indices, run-cycle counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx         <= '0;
      rdx         <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: if (start) begin
          idx     <= '0;
          rdx     <= '0;
          timeout <= 1'b0;
        end
        S_LOAD:  if (in_valid) idx <= idx + 16'd1;
        S_REQ:   cycle_count <= '0;
        S_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 16'd1;
          // core_done takes priority over the timeout on the same edge
          if (!core_done && cycle_count == RUN_LIMIT) timeout <= 1'b1;
        end
        S_DRAIN: if (res_ready) rdx <= rdx + 16'd1;
        default: ;
      endcase
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nx = FIRST;
      S_LOAD:  if (in_valid && idx == LOAD_LAST) state_nx = S_CRST;
      S_CRST:  state_nx = S_REQ;
      S_REQ:   state_nx = S_RUN;
      S_RUN: begin
        if (core_done)                     state_nx = AFTER_RUN;
        else if (cycle_count == RUN_LIMIT) state_nx = S_DONE;
      end
      S_DRAIN: if (res_ready && rdx == READ_LAST) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode; handshake strobes are masked while reset is asserted so an
  // abort mid-LOAD/DRAIN cannot commit one more byte
  always_comb begin
    in_ready   = 1'b0;
    mem_sel    = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wr_dat = '0;
    core_reset = 1'b0;
    core_req   = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;
    busy       = 1'b0;
    finished   = 1'b0;
    unique case (state)
      S_IDLE: core_reset = 1'b1;
      S_LOAD: begin
        busy       = 1'b1;
        mem_sel    = 1'b1;
        in_ready   = reset;
        mem_wr_en  = in_valid & reset;
        mem_addr   = LBASE + AW'(idx);
        mem_wr_dat = in_data;
      end
      S_CRST: begin
        busy       = 1'b1;
        core_reset = 1'b1;
      end
      S_REQ: begin
        busy     = 1'b1;
        core_req = 1'b1;
      end
      S_RUN: busy = 1'b1;
      S_DRAIN: begin
        busy      = 1'b1;
        mem_sel   = 1'b1;
        mem_addr  = RBASE + AW'(rdx);
        res_valid = reset;
        res_data  = mem_rd_dat;
      end
      S_DONE: begin
        finished   = 1'b1;
        core_reset = 1'b1;
      end
      default: core_reset = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_host_sequencer.sv
// Bench for host_sequencer: a stub core, a read-only result region, and
// scoreboards for memory writes and result bytes. Instance b shares all
// inputs but loads at FE to exercise address wrap.
module tb_host_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, res_ready;
  logic [7:0] in_data;
  logic       core_done;

  logic        in_ready, mem_sel, mem_wr_en, core_reset, core_req;
  logic        res_valid, busy, finished, timeout;
  logic [7:0]  mem_addr, mem_wr_dat, mem_rd_dat, res_data;
  logic [15:0] cycle_count;

  logic        b_in_ready, b_mem_sel, b_mem_wr_en, b_core_reset, b_core_req;
  logic        b_res_valid, b_busy, b_finished, b_timeout;
  logic [7:0]  b_mem_addr, b_mem_wr_dat, b_res_data;
  logic [15:0] b_cycle_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned res_hs   = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [7:0]  qr[$];

  int   stub_cnt = 0;
  int   done_delay = 0;
  logic stub_force = 1'b0;

  always #5 clk = ~clk;

  host_sequencer #(.AW(8), .LOAD_BASE(0), .LOAD_LEN(4), .READ_BASE(64),
                   .READ_LEN(2), .MAX_CYC(16'd20)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_sel(mem_sel),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_dat(mem_wr_dat),
    .mem_rd_dat(mem_rd_dat), .core_reset(core_reset), .core_req(core_req),
    .core_done(core_done), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .busy(busy), .finished(finished),
    .timeout(timeout), .cycle_count(cycle_count));

  host_sequencer #(.AW(8), .LOAD_BASE(254), .LOAD_LEN(4), .READ_BASE(64),
                   .READ_LEN(2), .MAX_CYC(16'd20)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(b_in_ready), .mem_sel(b_mem_sel),
    .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr), .mem_wr_dat(b_mem_wr_dat),
    .mem_rd_dat(8'h00), .core_reset(b_core_reset), .core_req(b_core_req),
    .core_done(core_done), .res_valid(b_res_valid), .res_data(b_res_data),
    .res_ready(res_ready), .busy(b_busy), .finished(b_finished),
    .timeout(b_timeout), .cycle_count(b_cycle_count));

  // Result region holds AA,BB at 64,65; everything else is filler
  assign mem_rd_dat = (mem_addr == 8'd64) ? 8'hAA :
                      (mem_addr == 8'd65) ? 8'hBB : (mem_addr ^ 8'h5A);

  // Stub core: raises done done_delay cycles after the req edge
  always @(posedge clk) begin
    if (core_reset)          stub_cnt <= 0;
    else if (core_req)       stub_cnt <= 1;
    else if (stub_cnt != 0)  stub_cnt <= stub_cnt + 1;
  end
  assign core_done = stub_force | ((done_delay != 0) && (stub_cnt >= done_delay));

  typedef struct {
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic [7:0] wr_addr;
    logic [5:0] exp;      // {busy,in_ready,core_reset,core_req,mem_sel,mem_wr_en}
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic push_wr(input logic [7:0] off, input logic [7:0] data);
    logic [7:0] ba;
    ba = 8'hFE + off;
    qa.push_back({off, data});
    qb.push_back({ba, data});
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mem_sel && mem_wr_en) begin
        if (qa.size() == 0) begin
          n_checks++;
          $display("FAIL wr_a_extra: got write %h@%h expected none", mem_wr_dat, mem_addr);
        end else check("wr_a", {16'h0, mem_addr, mem_wr_dat}, {16'h0, qa.pop_front()});
      end
      if (b_mem_sel && b_mem_wr_en) begin
        if (qb.size() == 0) begin
          n_checks++;
          $display("FAIL wr_b_extra: got write %h@%h expected none", b_mem_wr_dat, b_mem_addr);
        end else check("wr_b", {16'h0, b_mem_addr, b_mem_wr_dat}, {16'h0, qb.pop_front()});
      end
      if (res_valid && res_ready) begin
        res_hs++;
        if (qr.size() == 0) begin
          n_checks++;
          $display("FAIL res_extra: got byte %h expected none", res_data);
        end else check("res_data", {24'h0, res_data}, {24'h0, qr.pop_front()});
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] seed);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = seed + 8'(i);
      push_wr(8'(i), in_data);
      @(negedge clk);
      check("load_ready", {31'h0, in_ready}, 32'h1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_finished(input int budget, output int run_cyc);
    int n;
    run_cyc = 0;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (finished) break;
      if (busy && !mem_sel && !core_reset && !core_req) run_cyc++;
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      $display("FAIL wait_finished: got no finish expected finish within %0d cycles", budget);
    end
  endtask

  task automatic run_tests();
    vec_t tbl[8];
    int   rc, n, saved_hs;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 6'b001000};
    tbl[1] = '{1'b0, 1'b1, 8'h11, 8'h00, 6'b110011};
    tbl[2] = '{1'b0, 1'b1, 8'h22, 8'h01, 6'b110011};
    tbl[3] = '{1'b0, 1'b1, 8'h33, 8'h02, 6'b110011};
    tbl[4] = '{1'b0, 1'b1, 8'h44, 8'h03, 6'b110011};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b101000};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b100100};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b100000};

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {23'h0, busy, finished, timeout, res_valid, in_ready,
          mem_sel, mem_wr_en, core_req, core_reset}, 32'h1);
    check("reset_count", {16'h0, cycle_count}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Load, core reset and req sequencing, then 10-cycle run with stalled drain
    done_delay = 10;
    qr.push_back(8'hAA);
    qr.push_back(8'hBB);
    for (int i = 0; i < 8; i++) begin
      start    = tbl[i].start;
      in_valid = tbl[i].in_valid;
      in_data  = tbl[i].in_data;
      if (tbl[i].in_valid) push_wr(tbl[i].wr_addr, tbl[i].in_data);
      @(negedge clk);
      check($sformatf("tbl[%0d]", i), {26'h0, busy, in_ready, core_reset, core_req,
            mem_sel, mem_wr_en}, {26'h0, tbl[i].exp});
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 50);
    check("drain_reached", {31'h0, res_valid}, 32'h1);
    check("run_count_10", {16'h0, cycle_count}, 32'd10);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      check($sformatf("stall_valid[%0d]", i), {31'h0, res_valid}, 32'h1);
      check($sformatf("stall_data[%0d]", i), {24'h0, res_data}, 32'hAA);
      check($sformatf("stall_addr[%0d]", i), {24'h0, mem_addr}, 32'd64);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_finished(20, rc);
    check("t2_finished", {31'h0, finished}, 32'h1);
    check("t2_timeout", {31'h0, timeout}, 32'h0);
    check("t2_count", {16'h0, cycle_count}, 32'd10);
    check("t2_res_left", qr.size(), 32'h0);
    check("t2_res_hs", res_hs, 32'd2);

    // Timeout: core never finishes
    done_delay = 0;
    saved_hs = res_hs;
    pulse_start();
    do_load(8'h50);
    wait_finished(100, rc);
    check("t4_run_cycles", rc, 32'd20);
    check("t4_timeout", {31'h0, timeout}, 32'h1);
    check("t4_finished_idle", {30'h0, finished, busy}, 32'h2);
    check("t4_count", {16'h0, cycle_count}, 32'd20);
    check("t4_no_drain", res_hs, saved_hs);

    // Restart clears timeout; normal 5-cycle run
    done_delay = 5;
    qr.push_back(8'hAA);
    qr.push_back(8'hBB);
    pulse_start();
    check("t4_timeout_clr", {31'h0, timeout}, 32'h0);
    do_load(8'h60);
    wait_finished(50, rc);
    check("t4b_count", {16'h0, cycle_count}, 32'd5);
    check("t4b_timeout", {31'h0, timeout}, 32'h0);
    check("t4b_res_left", qr.size(), 32'h0);

    // Reset mid-LOAD after two of the toggled bytes
    done_delay = 0;
    pulse_start();
    in_valid = 1'b1; in_data = 8'hC0; push_wr(8'h00, 8'hC0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hC1; push_wr(8'h01, 8'hC1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hC2; reset = 1'b0;
    @(negedge clk);
    check("abort_wr_en", {31'h0, mem_wr_en}, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_idle", {28'h0, core_reset, busy, in_ready, mem_sel}, 32'h8);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_wr_a_left", qa.size(), 32'h0);
    check("abort_wr_b_left", qb.size(), 32'h0);
    check("abort_idle_after", {30'h0, core_reset, busy}, 32'h2);
    @(posedge clk); #1;

    // Wrapped load at FE on instance b; done held high before RUN
    stub_force = 1'b1;
    qr.push_back(8'hAA);
    qr.push_back(8'hBB);
    pulse_start();
    do_load(8'h70);
    wait_finished(50, rc);
    check("t6_count_a", {16'h0, cycle_count}, 32'd1);
    check("t6_count_b", {16'h0, b_cycle_count}, 32'd1);
    check("t6_timeout", {31'h0, timeout}, 32'h0);
    check("t6_wr_b_left", qb.size(), 32'h0);
    check("t6_res_left", qr.size(), 32'h0);
    stub_force = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    fork
      monitor();
      run_tests();
      begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion by 200000");
        $fatal(1, "watchdog");
      end
    join_any
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
